// File: rtl/input_debouncer_pkg.sv
// Shared defaults and sizing helper for the board-input debouncer.
// Imported by the top and by the per-channel debounce logic.
package input_debouncer_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_TICK_DIV     = 32000;
    localparam int DEF_STABLE_TICKS = 10;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-FF synchronizer, tick-qualified stability counter,
// registered level plus one-cycle rise/fall pulses coincident with the level change.
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din_bit,
    input  logic tick,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int            CW       = cnt_bits(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          sync;

    assign sync = sync_q[1];

    // NOTE: every signal gets its hold/idle value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        sync_d = {sync_q[0], din_bit};
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync == dout_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                dout_d = sync;
                cnt_d  = '0;
                rise_d = sync;
                fall_d = ~sync;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // their _d values from the same edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {2{RESET_VAL}};
            cnt_q  <= '0;
            dout_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Board-input conditioner: shared tick prescaler, one debounce_channel per pin,
// sticky edge-event register with irq and ack-clear (a new edge wins over ack).
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               TICK_DIV     = DEF_TICK_DIV,
    parameter int               STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] events,
    output logic             irq,
    input  logic             irq_ack
);

    localparam int            PW       = cnt_bits(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("input_debouncer: TICK_DIV must be >= 2");
    end
    if (STABLE_TICKS < 2) begin : g_bad_stable_ticks
        $error("input_debouncer: STABLE_TICKS must be >= 2");
    end

    logic [PW-1:0]    pre_q, pre_d;
    logic             tick;
    logic [WIDTH-1:0] events_q, events_d;

    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        pre_d    = tick ? '0 : pre_q + PW'(1);
        events_d = (events_q & ~{WIDTH{irq_ack}}) | rise | fall;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q    <= '0;
            events_q <= '0;
        end else begin
            pre_q    <= pre_d;
            events_q <= events_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_VAL    (RESET_VAL[i])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .din_bit (din[i]),
            .tick    (tick),
            .dout    (dout[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    assign events = events_q;
    assign irq    = |events_q;

endmodule
